// File: rtl/adc_xy_line_gen.sv
// adc_xy_line_gen: Bresenham vector generator that walks the beam from the current
// position to each accepted vertex, emitting one point per ADC sample strobe.
module adc_xy_line_gen #(
   parameter int ADC_DATA_BITS = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_en,
   input  logic                     vert_valid,
   output logic                     vert_ready,
   input  logic [ADC_DATA_BITS-1:0] vert_x,
   input  logic [ADC_DATA_BITS-1:0] vert_y,
   input  logic [2:0]               vert_rgb,
   input  logic                     vert_move,
   output logic [ADC_DATA_BITS-1:0] adc_x,
   output logic [ADC_DATA_BITS-1:0] adc_y,
   output logic                     adc_red,
   output logic                     adc_grn,
   output logic                     adc_blu,
   output logic                     sample_valid,
   output logic                     busy
);
   localparam int W = ADC_DATA_BITS;
   localparam int E = ADC_DATA_BITS + 2;
   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;
   state_t state_q, state_d;
   logic [W-1:0] x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
   logic [2:0] rgb_q, rgb_d, trgb_q, trgb_d;
   logic move_q, move_d, sxn_q, sxn_d, syn_q, syn_d, sv_q, sv_d, alive_q;
   logic signed [E-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, err_n;
   logic signed [E:0] e2, dxe, dye;
   logic [W-1:0] adx, ady, nx, ny;
   logic step_x, step_y;
   assign vert_ready   = alive_q && state_q == IDLE;
   assign busy         = state_q != IDLE;
   assign adc_x        = x_q;
   assign adc_y        = y_q;
   assign {adc_red, adc_grn, adc_blu} = rgb_q;
   assign sample_valid = sv_q;
   always_comb begin
      adx    = tx_q >= x_q ? tx_q - x_q : x_q - tx_q;
      ady    = ty_q >= y_q ? ty_q - y_q : y_q - ty_q;
      e2     = {err_q, 1'b0};
      dxe    = {dx_q[E-1], dx_q};
      dye    = {dy_q[E-1], dy_q};
      step_x = e2 >= dye;
      step_y = e2 <= dxe;
      nx     = step_x ? x_q + (sxn_q ? {W{1'b1}} : W'(1)) : x_q;
      ny     = step_y ? y_q + (syn_q ? {W{1'b1}} : W'(1)) : y_q;
      err_n  = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
   end
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      rgb_d   = rgb_q;
      trgb_d  = trgb_q;
      move_d  = move_q;
      sxn_d   = sxn_q;
      syn_d   = syn_q;
      err_d   = err_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sv_d    = 1'b0;
      case (state_q)
         IDLE: if (vert_valid && vert_ready) begin
            tx_d    = vert_x;
            ty_d    = vert_y;
            trgb_d  = vert_rgb;
            move_d  = vert_move;
            state_d = SETUP;
         end
         SETUP: begin
            dx_d    = E'(adx);
            dy_d    = -E'(ady);
            err_d   = E'(adx) - E'(ady);
            sxn_d   = tx_q < x_q;
            syn_d   = ty_q < y_q;
            x_d     = move_q ? tx_q : x_q;
            y_d     = move_q ? ty_q : y_q;
            rgb_d   = move_q ? 3'b000 : trgb_q;
            state_d = move_q ? IDLE : DRAW;
         end
         DRAW: if (sample_en) begin
            // a zero-length draw emits its single point without stepping
            sv_d = 1'b1;
            if (x_q == tx_q && y_q == ty_q) begin
               state_d = IDLE;
            end else begin
               x_d     = nx;
               y_d     = ny;
               err_d   = err_n;
               state_d = (nx == tx_q && ny == ty_q) ? IDLE : DRAW;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         rgb_q   <= '0;
         trgb_q  <= '0;
         move_q  <= 1'b0;
         sxn_q   <= 1'b0;
         syn_q   <= 1'b0;
         err_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         sv_q    <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         rgb_q   <= rgb_d;
         trgb_q  <= trgb_d;
         move_q  <= move_d;
         sxn_q   <= sxn_d;
         syn_q   <= syn_d;
         err_q   <= err_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sv_q    <= sv_d;
         alive_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_adc_xy_line_gen.sv
// tb_adc_xy_line_gen: table of vertices plus chaining and mid-line reset sequences,
// checked against a queue of expected points from a Bresenham reference.
module tb_adc_xy_line_gen;
   localparam int W = 10;
   logic clk = 0, reset_n = 0, sample_en = 0, vert_valid = 0, vert_move = 0;
   logic [W-1:0] vert_x = '0, vert_y = '0;
   logic [2:0] vert_rgb = '0;
   logic vert_ready, adc_red, adc_grn, adc_blu, sample_valid, busy;
   logic [W-1:0] adc_x, adc_y;
   adc_xy_line_gen #(.ADC_DATA_BITS(W)) dut (
      .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .vert_valid(vert_valid),
      .vert_ready(vert_ready), .vert_x(vert_x), .vert_y(vert_y), .vert_rgb(vert_rgb),
      .vert_move(vert_move), .adc_x(adc_x), .adc_y(adc_y), .adc_red(adc_red),
      .adc_grn(adc_grn), .adc_blu(adc_blu), .sample_valid(sample_valid), .busy(busy)
   );
   always #5 clk = ~clk;
   typedef struct {int x; int y; logic [2:0] rgb; bit move; bit gap; int n;} vec_t;
   typedef struct {int x; int y; int rgb;} pt_t;
   pt_t exp_q[$];
   vec_t vt[9];
   int checks = 0, errors = 0, cx = 0, cy = 0, nsamp = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Reference line walker: queues every point the generator should emit
   task automatic model(input int x1, input int y1, input int rgb);
      int dx, dy, sx, sy, err, e2, x, y;
      x = cx; y = cy;
      dx = x1 > x ? x1 - x : x - x1;
      dy = -(y1 > y ? y1 - y : y - y1);
      sx = x < x1 ? 1 : -1;
      sy = y < y1 ? 1 : -1;
      err = dx + dy;
      if (dx == 0 && dy == 0) exp_q.push_back('{x, y, rgb});
      while (!(x == x1 && y == y1)) begin
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
         exp_q.push_back('{x, y, rgb});
      end
      cx = x1; cy = y1;
   endtask
   task automatic tick();
      pt_t p;
      @(negedge clk);
      if (sample_valid) begin
         nsamp++;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_sample: got (%0d,%0d) expected none", adc_x, adc_y);
         end else begin
            p = exp_q.pop_front();
            chk("sample_x", int'(adc_x), p.x);
            chk("sample_y", int'(adc_y), p.y);
            chk("sample_rgb", int'({adc_red, adc_grn, adc_blu}), p.rgb);
         end
      end
   endtask
   task automatic run_line(input vec_t v);
      int t;
      bit prev_se;
      logic [W-1:0] hx, hy;
      t = 0;
      while (!vert_ready && t < 100) begin tick(); t++; end
      chk("ready_before_vertex", int'(vert_ready), 1);
      vert_x = W'(v.x); vert_y = W'(v.y); vert_rgb = v.rgb; vert_move = v.move; vert_valid = 1;
      if (v.move) begin cx = v.x; cy = v.y; end else model(v.x, v.y, int'(v.rgb));
      nsamp = 0;
      tick();
      vert_valid = 0;
      t = 0;
      while (busy && t < 5000) begin
         sample_en = v.gap ? ~sample_en : 1'b1;
         prev_se = sample_en; hx = adc_x; hy = adc_y;
         tick();
         if (!prev_se) begin
            chk("hold_x", int'(adc_x), int'(hx));
            chk("hold_y", int'(adc_y), int'(hy));
            chk("hold_valid", int'(sample_valid), 0);
         end
         t++;
      end
      sample_en = 0;
      chk("line_done_in_time", int'(busy), 0);
      chk("line_samples", nsamp, v.n);
      chk("ready_after_line", int'(vert_ready), 1);
      chk("end_x", int'(adc_x), v.x);
      chk("end_y", int'(adc_y), v.y);
      if (v.move) chk("move_colour", int'({adc_red, adc_grn, adc_blu}), 0);
   endtask
   initial begin
      int t, idx, xfers, zeros, gaps;
      bit seen, xfer;
      vec_t ch[3];
      vt[0] = '{1023, 0, 3'b111, 1'b0, 1'b0, 1023};
      vt[1] = '{0, 0, 3'b000, 1'b1, 1'b0, 0};
      vt[2] = '{3, 10, 3'b010, 1'b0, 1'b0, 10};
      vt[3] = '{500, 200, 3'b011, 1'b1, 1'b0, 0};
      vt[4] = '{500, 200, 3'b100, 1'b0, 1'b0, 1};
      vt[5] = '{0, 0, 3'b000, 1'b1, 1'b0, 0};
      vt[6] = '{8, 8, 3'b001, 1'b0, 1'b1, 8};
      vt[7] = '{2, 20, 3'b011, 1'b0, 1'b0, 12};
      vt[8] = '{0, 0, 3'b101, 1'b0, 1'b0, 20};
      ch[0] = '{4, 0, 3'b110, 1'b0, 1'b0, 4};
      ch[1] = '{4, 4, 3'b010, 1'b0, 1'b0, 4};
      ch[2] = '{0, 0, 3'b001, 1'b0, 1'b0, 4};
      tick(); tick();
      chk("rst_x", int'(adc_x), 0);
      chk("rst_y", int'(adc_y), 0);
      chk("rst_rgb", int'({adc_red, adc_grn, adc_blu}), 0);
      chk("rst_ready", int'(vert_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(sample_valid), 0);
      reset_n = 1;
      tick();
      chk("ready_after_reset", int'(vert_ready), 1);
      for (int i = 0; i < 9; i++) run_line(vt[i]);
      // three vertices offered back to back with vert_valid held high
      idx = 0; xfers = 0; zeros = 0; gaps = 0; seen = 0; t = 0;
      vert_x = W'(ch[0].x); vert_y = W'(ch[0].y); vert_rgb = ch[0].rgb; vert_move = 0; vert_valid = 1;
      model(ch[0].x, ch[0].y, int'(ch[0].rgb));
      sample_en = 1;
      while (t < 500 && !(xfers == 3 && !busy && exp_q.size() == 0)) begin
         xfer = vert_valid && vert_ready;
         tick();
         if (xfer) begin
            xfers++;
            if (idx < 2) begin
               idx++;
               vert_x = W'(ch[idx].x); vert_y = W'(ch[idx].y); vert_rgb = ch[idx].rgb;
               model(ch[idx].x, ch[idx].y, int'(ch[idx].rgb));
            end else vert_valid = 0;
         end
         if (sample_valid) begin
            if (seen) gaps += zeros;
            zeros = 0; seen = 1;
         end else if (seen) zeros++;
         t++;
      end
      sample_en = 0; vert_valid = 0;
      chk("chain_transfers", xfers, 3);
      chk("chain_gap_cycles", gaps, 4);
      chk("chain_pending", exp_q.size(), 0);
      tick();
      // reset in the middle of a long diagonal
      vert_x = W'(1023); vert_y = W'(1023); vert_rgb = 3'b110; vert_move = 0; vert_valid = 1;
      model(1023, 1023, 6);
      nsamp = 0; t = 0;
      tick();
      vert_valid = 0; sample_en = 1;
      while (nsamp < 100 && t < 1000) begin tick(); t++; end
      chk("samples_before_reset", nsamp, 100);
      reset_n = 0;
      exp_q.delete();
      tick();
      chk("midrst_x", int'(adc_x), 0);
      chk("midrst_y", int'(adc_y), 0);
      chk("midrst_rgb", int'({adc_red, adc_grn, adc_blu}), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      chk("midrst_ready", int'(vert_ready), 0);
      reset_n = 1;
      cx = 0; cy = 0; nsamp = 0;
      tick();
      chk("midrst_ready_after", int'(vert_ready), 1);
      for (int i = 0; i < 30; i++) tick();
      chk("midrst_no_samples", nsamp, 0);
      chk("midrst_busy", int'(busy), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adc_xy_line_gen.md
ADC_XY_LINE_GEN -- requirements
Module: adc_xy_line_gen

Interface
REQ-001 SHALL have parameter ADC_DATA_BITS, default 10, the width of the X/Y coordinates.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port sample_en, input, 1 bit, the ADC-rate strobe; one point may advance per strobe.
REQ-005 SHALL have port vert_valid, input, 1 bit, marking the vertex command as valid.
REQ-006 SHALL have port vert_ready, output, 1 bit; the generator accepts a vertex when it is high.
REQ-007 SHALL have ports vert_x and vert_y, input, ADC_DATA_BITS each, the target coordinate.
REQ-008 SHALL have port vert_rgb, input, 3 bits, the line colour as {red, grn, blu}.
REQ-009 SHALL have port vert_move, input, 1 bit; 1 means pen-up move and 0 means draw a line.
REQ-010 SHALL have ports adc_x and adc_y, output, ADC_DATA_BITS each, the current beam position.
REQ-011 SHALL have ports adc_red, adc_grn and adc_blu, output, 1 bit each, the beam colour.
REQ-012 SHALL have port sample_valid, output, 1 bit, a one-cycle pulse marking an emitted point.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-014 SHALL implement exactly three states: IDLE, SETUP and DRAW.
REQ-015 SHALL drive vert_ready=1 only in IDLE; a transfer is vert_valid && vert_ready.
REQ-016 SHALL, on a transfer, latch the target and colour and enter SETUP on the next cycle.
REQ-017 SHALL, in SETUP (exactly 1 cycle), compute:
  - dx = |x1-x0|, dy = -|y1-y0|;
  - sx and sy as +1 or -1;
  - err = dx+dy;
  - error and delta registers as signed, ADC_DATA_BITS+2 bits wide, so there is no overflow.
REQ-018 SHALL, when a SETUP move command (vert_move=1) executes:
  - load the current position with the target;
  - force the colour outputs to 0;
  - emit no sample;
  - return to IDLE.
REQ-019 SHALL, for a SETUP draw command, enter DRAW with the colour outputs set to vert_rgb.
REQ-020 SHALL, in DRAW on sample_en=1, apply one Bresenham step, register it onto adc_x/adc_y, and pulse sample_valid on the following cycle:
  - e2 = 2*err;
  - if e2 >= dy then err += dy and x += sx;
  - if e2 <= dx then err += dx and y += sy.
REQ-021 SHALL, in DRAW on sample_en=0, hold the position, err and outputs, with sample_valid=0.
REQ-022 SHALL, on the strobe whose step lands on the endpoint, go to IDLE with that point emitted.
REQ-023 SHALL emit exactly max(dx,|dy|) samples per draw, including the endpoint and excluding the start point.
REQ-024 SHALL, for a zero-length draw (target equals current position), emit exactly one sample at that point on the first strobe and then go to IDLE.
REQ-025 SHALL leave the outputs holding the last point and colour in IDLE, with sample_valid=0.
REQ-026 SHALL keep coordinate steps in the range 0..2^ADC_DATA_BITS-1 by construction, so that no wrap-around occurs.
REQ-027 SHALL ignore sample_en outside DRAW.
REQ-028 SHALL assert vert_ready again in the cycle after the last sample is emitted, so back-to-back vertices chain with 2 idle cycles (IDLE, then SETUP).

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, set:
  - state to IDLE;
  - adc_x, adc_y, colours, sample_valid and busy to 0;
  - vert_ready to 0;
  - err, dx and dy to 0.
REQ-030 SHALL assert vert_ready=1 in the first cycle after reset_n returns to 1.
REQ-031 SHALL, on reset asserted mid-DRAW, abandon the line immediately, with no further samples after reset and the position reset to (0,0).

Verification
REQ-032 SHALL be verified with a horizontal line: from (0,0), draw to (1023,0) with rgb=3'b111 and sample_en held at 1 -> 1023 samples; x steps 1..1023, y=0; busy falls after the last sample.
REQ-033 SHALL be verified with a steep line: from (0,0), draw to (3,10) -> 10 samples; y steps 1..10 monotonically; x is non-decreasing and ends at 3; every step has |dx|<=1.
REQ-034 SHALL be verified with move then dot: move to (500,200), then draw to (500,200) with rgb=3'b100 ->
  - the move gives no sample and colour 0;
  - the draw gives exactly one sample at (500,200) with red=1.
REQ-035 SHALL be verified with a gapped strobe: draw from (0,0) to (8,8) with sample_en toggling 1,0,1,0 -> 8 samples, one per strobe; the outputs are stable while sample_en=0.
REQ-036 SHALL be verified with reset mid-line: during a draw to (1023,1023), drop reset_n for 1 cycle after 100 samples ->
  - no sample_valid afterwards;
  - outputs (0,0,0);
  - vert_ready=1 in the first cycle after reset_n returns to 1.
REQ-037 SHALL be verified with chaining: vert_valid held high with 3 queued vertices -> vert_ready pulses once per vertex; there are exactly 2 non-drawing cycles between consecutive lines.
